// File: rtl/sipo_holding_reg.sv
// Purpose: valid/ready output holding register for completed words, with sticky overrun.
// Latency: a written word is visible on o_q/o_out_valid the cycle after i_wr.
// Backpressure: a write while full and not draining is dropped and sets o_overrun.
// Ports: clk/rst (sync, active-high); i_wr/i_wr_dat new word; i_out_ready consumer accept;
//        o_q held word; o_out_valid word pending; o_overrun sticky drop flag.
module sipo_holding_reg #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_wr,
  input  logic [1:WIDTH] i_wr_dat,
  input  logic           i_out_ready,
  output logic [1:WIDTH] o_q,
  output logic           o_out_valid,
  output logic           o_overrun
);

  logic [1:WIDTH] r_q;
  logic           r_vld;
  logic           r_ovr;
  logic           w_xfer;
  logic           w_blocked;

  assign w_xfer    = r_vld & i_out_ready;
  // Only a pending word that is not leaving this cycle blocks a new write.
  assign w_blocked = r_vld & ~i_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_vld <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (i_wr && !w_blocked) begin
        r_q   <= i_wr_dat;
        r_vld <= 1'b1;
      end else if (w_xfer) begin
        r_vld <= 1'b0;
      end
      if (i_wr && w_blocked) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign o_q         = r_q;
  assign o_out_valid = r_vld;
  assign o_overrun   = r_ovr;

endmodule

// File: rtl/sipo_deserializer.sv
// Purpose: framed serial-in/parallel-out deserializer; rebuilds WIDTH-bit words (first bit = x[WIDTH]).
// Latency: q/out_valid update on the same edge that samples the final bit of a frame.
// Backpressure: none toward the line; a word completing into a full holder is dropped (overrun).
// Ports: clk, rst (sync, active-high); bit_en qualifies sync/din; out_ready consumer accept;
//        q word x[1:WIDTH]; out_valid pending; overrun sticky; abort one-cycle partial-frame discard.
module sipo_deserializer #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bit_en,
  input  logic           sync,
  input  logic           din,
  input  logic           out_ready,
  output logic [1:WIDTH] q,
  output logic           out_valid,
  output logic           overrun,
  output logic           abort
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:WIDTH] r_sh;
  logic           r_abort;

  logic           w_in_shift;
  logic           w_done;
  logic [1:WIDTH] w_shifted;

  assign w_in_shift = (r_state == S_SHIFT);
  // New bit enters at index 1; older bits move toward index WIDTH.
  assign w_shifted  = {din, r_sh[1:WIDTH-1]};
  // A sync on the last bit position restarts the frame instead of completing it.
  assign w_done     = w_in_shift & bit_en & ~sync & (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_in_shift & bit_en & sync;
      if (bit_en) begin
        if (sync) begin
          r_sh    <= w_shifted;
          r_cnt   <= CNT_W'(1);
          r_state <= S_SHIFT;
        end else if (w_in_shift) begin
          r_sh <= w_shifted;
          if (w_done) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  sipo_holding_reg #(.WIDTH(WIDTH)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .i_wr        (w_done),
    .i_wr_dat    (w_shifted),
    .i_out_ready (out_ready),
    .o_q         (q),
    .o_out_valid (out_valid),
    .o_overrun   (overrun)
  );

  assign abort = r_abort;

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       sync = 1'b0;
  logic       din = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:4] q;
  logic       out_valid;
  logic       overrun;
  logic       abort;

  int checks = 0;
  int failures = 0;

  sipo_deserializer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .sync      (sync),
    .din       (din),
    .out_ready (out_ready),
    .q         (q),
    .out_valid (out_valid),
    .overrun   (overrun),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  // Present one qualified bit for one edge; outputs are sampled 1ns after that edge.
  task automatic send_bit(input logic s, input logic d);
    @(negedge clk);
    bit_en = 1'b1;
    sync   = s;
    din    = d;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    sync   = 1'b0;
    din    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends x[4] first (with sync) down to x[1]; counts abort pulses seen after each
  // bit and out_valid seen before the final bit.
  task automatic send_word(input logic [1:4] x, output int n_abort, output int n_early);
    n_abort = 0;
    n_early = 0;
    for (int i = 4; i >= 1; i--) begin
      send_bit(i == 4, x[i]);
      if (abort) n_abort++;
      if (i != 1 && out_valid) n_early++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if ({q, out_valid, overrun, abort} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got q=%b vld=%b ovr=%b abort=%b, expected all 0", q, out_valid, overrun, abort);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: got %b expected 0", out_valid);
    end
    send_bit(1'b0, 1'b1);
    checks++;
    if (q !== 4'b1101 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL basic_word: got q=%b vld=%b ovr=%b expected q=1101 vld=1 ovr=0", q, out_valid, overrun);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle: got vld=%b expected 0", out_valid);
    end
  endtask

  task automatic test_gapped();
    int early = 0;
    logic [1:4] x = 4'b1101;
    out_ready = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      send_bit(i == 4, x[i]);
      if (i != 1) begin
        if (out_valid) early++;
        for (int g = 0; g < 3; g++) begin
          idle(1);
          if (out_valid) early++;
        end
      end
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL gapped_early_valid: got %0d cycles expected 0", early);
    end
    checks++;
    if (q !== 4'b1101 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL gapped_word: got q=%b vld=%b expected q=1101 vld=1", q, out_valid);
    end
    idle(1);
  endtask

  task automatic test_overrun();
    int na, ne;
    out_ready = 1'b0;
    send_word(4'b1010, na, ne);
    checks++;
    if (q !== 4'b1010 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first: got q=%b vld=%b ovr=%b expected q=1010 vld=1 ovr=0", q, out_valid, overrun);
    end
    send_word(4'b0110, na, ne);
    checks++;
    if (q !== 4'b1010 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_dropped: got q=%b vld=%b ovr=%b expected q=1010 vld=1 ovr=1", q, out_valid, overrun);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_drain: got vld=%b ovr=%b expected vld=0 ovr=1", out_valid, overrun);
    end
    idle(3);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_reset_clear: got %b expected 0", overrun);
    end
  endtask

  task automatic test_simul();
    int na, ne;
    out_ready = 1'b0;
    send_word(4'b0011, na, ne);
    // B = 1100 sent x[4]..x[1] = 0,0,1,1; ready only on the final bit's edge.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    checks++;
    if (q !== 4'b0011 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL simul_hold_a: got q=%b vld=%b expected q=0011 vld=1", q, out_valid);
    end
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    checks++;
    if (q !== 4'b1100 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL simul_word: got q=%b vld=%b ovr=%b expected q=1100 vld=1 ovr=0", q, out_valid, overrun);
    end
    idle(1);
  endtask

  task automatic test_abort();
    int na, ne;
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_word(4'b1001, na, ne);
    checks++;
    if (na !== 1 || ne !== 0) begin
      failures++;
      $display("FAIL abort_mid: got aborts=%0d early_vld=%0d expected aborts=1 early_vld=0", na, ne);
    end
    checks++;
    if (q !== 4'b1001 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_word: got q=%b vld=%b expected q=1001 vld=1", q, out_valid);
    end
    idle(1);
    // Sync arriving on the last bit position restarts rather than completes.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_word(4'b0110, na, ne);
    checks++;
    if (na !== 1 || ne !== 0 || q !== 4'b0110 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_last_bit: got aborts=%0d early=%0d q=%b vld=%b expected 1 0 0110 1", na, ne, q, out_valid);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    int na, ne;
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    @(negedge clk);
    rst    = 1'b1;
    bit_en = 1'b1;
    din    = 1'b1;
    idle(2);
    checks++;
    if ({q, out_valid, overrun, abort} !== 7'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got q=%b vld=%b ovr=%b abort=%b expected all 0", q, out_valid, overrun, abort);
    end
    @(negedge clk);
    rst    = 1'b0;
    bit_en = 1'b0;
    din    = 1'b0;
    send_word(4'b0101, na, ne);
    checks++;
    if (na !== 0 || ne !== 0 || q !== 4'b0101 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_word: got aborts=%0d early=%0d q=%b vld=%b expected 0 0 0101 1", na, ne, q, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_simul();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
